// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default sizes.
package counter_ctrl_pkg;

    localparam int DEF_WIDTH  = 5;
    localparam int DEF_TCNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Command channel of the counter sequencer: interval command over valid/ready.
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_limit;
    logic             cmd_auto;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_limit,
        output cmd_auto,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_limit,
        input  cmd_auto,
        output cmd_ready
    );
endinterface

// File: rtl/counter.sv
// Loadable up-counter: load has priority over enable, wraps modulo 2^WIDTH.
module counter
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out
);

    // Count register: preset on load, increment on enab, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_out <= {WIDTH{1'b0}};
        end else if (load) begin
            cnt_out <= cnt_in;
        end else if (enab) begin
            cnt_out <= cnt_out + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_out <= cnt_out;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for a loadable up-counter: accepts an interval command, loads and
// enables the counter, detects terminal count, pulses tick per interval and
// keeps a saturating tally of completed intervals since the last accept.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int TCNT_W = DEF_TCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    counter_ctrl_if.slave     cmd,
    input  logic              pause,
    input  logic              abort,
    output logic              cnt_load,
    output logic              cnt_enab,
    output logic [WIDTH-1:0]  cnt_in,
    input  logic [WIDTH-1:0]  cnt_out,
    output logic              busy,
    output logic              tick,
    output logic [TCNT_W-1:0] tick_cnt
);

    // Tally increment that sticks at all-ones instead of wrapping.
    function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(TCNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [WIDTH-1:0]    start_r;
    logic [WIDTH-1:0]    limit_r;
    logic                auto_r;
    logic                tick_r;
    logic [TCNT_W-1:0]   tick_cnt_r;

    logic                accept_s;
    logic                at_limit_s;
    logic                terminal_s;

    assign accept_s   = (state_r == ST_IDLE) && cmd.cmd_valid;
    assign at_limit_s = (cnt_out == limit_r);
    // Abort and pause both veto the terminal event in the same cycle.
    assign terminal_s = (state_r == ST_RUN) && at_limit_s && !pause && !abort;

    // Outputs toward the counter and the command channel follow the state directly
    // so an async reset releases the counter within the same cycle.
    assign cmd.cmd_ready = (state_r == ST_IDLE);
    assign busy          = (state_r != ST_IDLE);
    assign cnt_load      = (state_r == ST_LOAD);
    assign cnt_enab      = (state_r == ST_RUN) && !pause && !at_limit_s;
    assign cnt_in        = start_r;
    assign tick          = tick_r;
    assign tick_cnt      = tick_cnt_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; abort wins over both load and terminal.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (terminal_s) begin
                    if (auto_r) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Command fields are captured only on accept and held for reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r <= {WIDTH{1'b0}};
            limit_r <= {WIDTH{1'b0}};
            auto_r  <= 1'b0;
        end else if (accept_s) begin
            start_r <= cmd.cmd_start;
            limit_r <= cmd.cmd_limit;
            auto_r  <= cmd.cmd_auto;
        end else begin
            start_r <= start_r;
            limit_r <= limit_r;
            auto_r  <= auto_r;
        end
    end

    // Tick pulse and completed-interval tally; the tally restarts on every accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r     <= 1'b0;
            tick_cnt_r <= {TCNT_W{1'b0}};
        end else begin
            tick_r <= terminal_s;
            if (accept_s) begin
                tick_cnt_r <= {TCNT_W{1'b0}};
            end else if (terminal_s) begin
                tick_cnt_r <= sat_inc(tick_cnt_r);
            end else begin
                tick_cnt_r <= tick_cnt_r;
            end
        end
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Sequencer for the team's loadable up-counter (the `counter` module, WIDTH-parameterised). It accepts an interval command (start value, terminal value, one-shot/auto-reload) over a valid/ready handshake. It then drives the counter's load/enab/cnt_in and watches cnt_out for terminal count. It emits a one-cycle tick per completed interval and supports pause and abort. It sits beside a `counter` instance at the integration level; its outputs connect directly to that instance's load/enab/cnt_in, and the instance's cnt_out feeds back in.

Parameters:
WIDTH, 5, counter width; matches the controlled counter instance
TCNT_W, 8, width of the completed-interval tally

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when high with cmd_valid at posedge
cmd_start  input  WIDTH  counter preset value
cmd_limit  input  WIDTH  terminal value
cmd_auto  input  1  1 = auto-reload after terminal, 0 = one-shot
pause  input  1  freeze counting while high
abort  input  1  cancel current interval
cnt_load  output  1  to counter load
cnt_enab  output  1  to counter enab
cnt_in  output  WIDTH  to counter cnt_in
cnt_out  input  WIDTH  from counter cnt_out
busy  output  1  high in any state other than IDLE
tick  output  1  one-cycle pulse per completed interval
tick_cnt  output  TCNT_W  completed intervals since last accept; saturating

Behaviour:
- Counter contract: on posedge, load=1 loads cnt_in (load has priority); otherwise enab=1 increments modulo 2^WIDTH (1F->00 at WIDTH=5); otherwise holds.
- Reset (async, immediate): state=IDLE; tick=0, tick_cnt=0, latched start/limit/auto=0.
- Reset values of derived outputs: cnt_in=0, cnt_load=0, cnt_enab=0, busy=0, cmd_ready=1.
- This block does not reset the counter; it only stops driving it.
- States: IDLE, LOAD, RUN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at posedge: latch start/limit/auto, clear tick_cnt, go LOAD.
  - abort and pause are ignored.
- LOAD (exactly one cycle):
  - cnt_load=1, cnt_enab=0, cnt_in=latched start.
  - Go RUN, unless abort, which goes IDLE.
  - pause does not block the load.
- RUN:
  - cnt_load=0.
  - cnt_enab = !pause && (cnt_out != limit).
  - Terminal condition: cnt_out==limit && !pause && !abort.
  - On terminal: next cycle tick=1 and tick_cnt+1 (holds at all-ones); next state is LOAD if auto, else IDLE.
- cmd_ready=0 outside IDLE; commands offered while busy are not accepted.
- Outputs cmd_ready, busy, cnt_load, cnt_enab and cnt_in are decoded from the registered state and latched fields. tick and tick_cnt are registered.
- Timing: let d = (limit - start) mod 2^WIDTH.
  - RUN lasts d+1 unpaused cycles.
  - Accept-to-tick latency is d+2 cycles plus pause cycles.
  - Auto-reload period is d+2 cycles.
  - limit < start wraps through zero.
  - start==limit gives d=0: tick two cycles after accept, auto period 2.
- abort:
  - Priority over terminal and over load in the same cycle.
  - Goes IDLE with no tick and tick_cnt unchanged.
  - The counter holds its value because enab is 0.
- pause in RUN freezes the counter and suppresses terminal detection. Counting resumes on the first cycle pause is low.
- Async reset mid-RUN forces IDLE immediately, without waiting for a clock edge.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2) and the default WIDTH.
- No sub-module inside counter_ctrl; the terminal compare and the saturating tally are inline.
- The existing `counter` is instantiated alongside it at the integration level and in the bench, which checks both together.

Test Plan:
1. Reset, cmd start=03 limit=06 auto=0 -> one LOAD cycle with cnt_in=03; cnt_out 03,04,05,06; tick one cycle after 06 first seen; busy=0, tick_cnt=1, cnt_out holds 06.
2. start=1E limit=01 one-shot -> cnt_out 1E,1F,00,01; tick 5 cycles after accept.
3. start=00 limit=02 auto=1 -> tick every 4 cycles; after 3 ticks tick_cnt=3; assert abort in RUN -> IDLE, cmd_ready=1, no further tick, tick_cnt stays 3.
4. start=10 limit=12 auto=0, pause high for 3 cycles when cnt_out=11 -> cnt_out holds 11 for 3 cycles; tick delayed by exactly 3 cycles versus the unpaused case.
5. start=limit=07 auto=1 -> tick every 2 cycles; cmd_valid with new values while busy is not accepted (cmd_ready=0), and the latched values are unchanged.
6. Assert rst between clock edges during RUN -> busy, cnt_enab and tick go 0 and cmd_ready goes 1 before the next edge; tick_cnt=0; after release, a new command is accepted normally.
